// File: rtl/car_sequencer_if.sv
// Handshake/bus bundle between the microsequencer and its environment.
// master drives memory data and qualifiers; slave returns CAR/IR and pulses.
interface car_sequencer_if #(
    parameter int CAR_BITS = 6
);
    logic [15:0]         mdb_in;
    logic                stall;
    logic                int_req;
    logic [CAR_BITS-1:0] car;
    logic [15:0]         ir;
    logic                int_ack;
    logic                instr_done;
    logic                illegal;

    modport master (
        output mdb_in, stall, int_req,
        input  car, ir, int_ack, instr_done, illegal
    );

    modport slave (
        input  mdb_in, stall, int_req,
        output car, ir, int_ack, instr_done, illegal
    );
endinterface

// File: rtl/car_sequencer.sv
// Microsequencer: owns IR and CAR, walks the micro-step sequence of each
// instruction and inserts the interrupt entry sequence at boundaries.
module car_sequencer #(
    parameter int CAR_BITS = 6
) (
    input  logic            clk,
    input  logic            rst,
    car_sequencer_if.slave  bus
);

    typedef logic [CAR_BITS-1:0] car_t;

    typedef enum logic [1:0] {
        SRC_REG,
        SRC_IDX,
        SRC_IND
    } src_t;

    localparam car_t CAR_0     = car_t'(0);
    localparam car_t REG_REG   = car_t'(1);
    localparam car_t REG_IDX0  = car_t'(2);
    localparam car_t IND_REG0  = car_t'(6);
    localparam car_t IND_IDX0  = car_t'(8);
    localparam car_t IDX_REG0  = car_t'(13);
    localparam car_t IDX_IDX0  = car_t'(16);
    localparam car_t OP1_REG   = car_t'(22);
    localparam car_t OP1_IND0  = car_t'(23);
    localparam car_t OP1_IDX0  = car_t'(26);
    localparam car_t PUSH_REG0 = car_t'(30);
    localparam car_t PUSH_IND0 = car_t'(33);
    localparam car_t PUSH_IDX0 = car_t'(36);
    localparam car_t CALL_REG0 = car_t'(40);
    localparam car_t CALL_IND0 = car_t'(43);
    localparam car_t CALL_IDX0 = car_t'(46);
    localparam car_t RETI0     = car_t'(50);
    localparam car_t INT0      = car_t'(52);
    localparam car_t INT4      = car_t'(56);
    localparam car_t JMP       = car_t'(57);
    localparam car_t CAR_LAST  = car_t'(57);

    // Constant-generator encodings (R3 any mode, R2 @/@+) read as register.
    // R2 indexed is absolute and PC @+ is immediate, so those keep their class.
    function automatic src_t src_class(input logic [1:0] as_f,
                                       input logic [3:0] r);
        if (r == 4'd3 || (r == 4'd2 && as_f[1]))
            return SRC_REG;
        case (as_f)
            2'b00:   return SRC_REG;
            2'b01:   return SRC_IDX;
            default: return SRC_IND;
        endcase
    endfunction

    function automatic car_t pick(input src_t s, input car_t r,
                                  input car_t n, input car_t x);
        case (s)
            SRC_IDX: return x;
            SRC_IND: return n;
            default: return r;
        endcase
    endfunction

    // Final step of every instruction sequence (INT4 handled separately).
    function automatic logic is_last(input car_t c);
        case (int'(c))
            1, 5, 7, 12, 15, 21, 22, 25, 29,
            32, 35, 39, 42, 45, 49, 51, 57: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

    car_t        car_q, car_d;
    logic [15:0] ir_q, ir_d;
    logic        int_ack_q, int_ack_d;
    logic        done_q, done_d;
    logic        illegal_q, illegal_d;

    car_t        dec_car;
    logic        dec_bad;
    src_t        src_fi;
    src_t        src_op;

    // Decode the word on the bus into the first step of its sequence.
    always_comb begin
        dec_car = CAR_0;
        dec_bad = 1'b0;
        src_fi  = src_class(bus.mdb_in[5:4], bus.mdb_in[11:8]);
        src_op  = src_class(bus.mdb_in[5:4], bus.mdb_in[3:0]);
        if (bus.mdb_in[15:13] == 3'b001) begin
            dec_car = JMP;
        end else if (bus.mdb_in[15:10] == 6'b000100) begin
            case (bus.mdb_in[9:7])
                3'b000, 3'b001, 3'b010, 3'b011:
                    dec_car = pick(src_op, OP1_REG, OP1_IND0, OP1_IDX0);
                3'b100:
                    dec_car = pick(src_op, PUSH_REG0, PUSH_IND0, PUSH_IDX0);
                3'b101:
                    dec_car = pick(src_op, CALL_REG0, CALL_IND0, CALL_IDX0);
                3'b110:
                    dec_car = RETI0;
                default:
                    dec_bad = 1'b1;
            endcase
        end else if (bus.mdb_in[15:12] >= 4'd4) begin
            if (bus.mdb_in[7])
                dec_car = pick(src_fi, REG_IDX0, IND_IDX0, IDX_IDX0);
            else
                dec_car = pick(src_fi, REG_REG, IND_REG0, IDX_REG0);
        end else begin
            dec_bad = 1'b1;
        end
    end

    // Next CAR/IR and the pulses that accompany this edge.
    always_comb begin
        car_d     = car_q;
        ir_d      = ir_q;
        int_ack_d = 1'b0;
        done_d    = 1'b0;
        illegal_d = 1'b0;
        if (!bus.stall) begin
            if (car_q == CAR_0) begin
                ir_d      = bus.mdb_in;
                car_d     = dec_car;
                illegal_d = dec_bad;
            end else if (car_q == INT4) begin
                car_d     = CAR_0;
                int_ack_d = 1'b1;
            end else if (car_q > CAR_LAST) begin
                car_d = CAR_0;
            end else if (is_last(car_q)) begin
                done_d = 1'b1;
                car_d  = bus.int_req ? INT0 : CAR_0;
            end else begin
                car_d = car_q + car_t'(1);
            end
        end
    end

    // State and registered pulse outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            car_q     <= CAR_0;
            ir_q      <= 16'h0000;
            int_ack_q <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            car_q     <= car_d;
            ir_q      <= ir_d;
            int_ack_q <= int_ack_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.car        = car_q;
    assign bus.ir         = ir_q;
    assign bus.int_ack    = int_ack_q;
    assign bus.instr_done = done_q;
    assign bus.illegal    = illegal_q;

endmodule

// File: tb/tb_car_sequencer.sv
// Directed bench for car_sequencer: instruction sequences, interrupts,
// illegal opcodes, stall and asynchronous reset.
module tb_car_sequencer;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    car_sequencer_if #(.CAR_BITS(6)) bus ();

    car_sequencer #(.CAR_BITS(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rst         = 1'b1;
        bus.int_req = 1'b1;
        bus.stall   = 1'b0;
        bus.mdb_in  = 16'h4405;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.car !== 6'd0 || bus.ir !== 16'h0000 ||
            {bus.int_ack, bus.instr_done, bus.illegal} !== 3'b000) begin
            errors++;
            $display("FAIL reset: car=%0d ir=%h pulses=%b, expected car=0 ir=0000 pulses=000",
                     bus.car, bus.ir, {bus.int_ack, bus.instr_done, bus.illegal});
        end
        bus.stall   = 1'b1;
        bus.int_req = 1'b0;
        rst         = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.car !== 6'd0 || bus.ir !== 16'h0000) begin
            errors++;
            $display("FAIL reset_release: car=%0d ir=%h, expected car=0 ir=0000",
                     bus.car, bus.ir);
        end
    endtask

    task automatic test_mov_reg();
        int         ec [2] = '{1, 0};
        logic [2:0] ep [2] = '{3'b000, 3'b010};
        bus.mdb_in = 16'h4405;
        bus.stall  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (int'(bus.car) !== ec[i] || bus.ir !== 16'h4405 ||
                {bus.int_ack, bus.instr_done, bus.illegal} !== ep[i]) begin
                errors++;
                $display("FAIL mov_reg step %0d: car=%0d ir=%h pulses=%b, expected car=%0d ir=4405 pulses=%b",
                         i, bus.car, bus.ir, {bus.int_ack, bus.instr_done, bus.illegal}, ec[i], ep[i]);
            end
        end
        bus.stall = 1'b1;
    endtask

    task automatic test_add_ind_idx();
        int         ec [6] = '{8, 9, 10, 11, 12, 0};
        logic [2:0] ep [6] = '{0, 0, 0, 0, 0, 3'b010};
        bus.mdb_in = 16'h54B5;
        bus.stall  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (int'(bus.car) !== ec[i] || bus.ir !== 16'h54B5 ||
                {bus.int_ack, bus.instr_done, bus.illegal} !== ep[i]) begin
                errors++;
                $display("FAIL add_ind_idx step %0d: car=%0d ir=%h pulses=%b, expected car=%0d ir=54b5 pulses=%b",
                         i, bus.car, bus.ir, {bus.int_ack, bus.instr_done, bus.illegal}, ec[i], ep[i]);
            end
        end
        bus.stall = 1'b1;
    endtask

    task automatic test_push_const_abs();
        logic [15:0] w  [3]    = '{16'h1204, 16'h4305, 16'h4215};
        int          n  [3]    = '{4, 2, 4};
        int          ec [3][4] = '{'{30, 31, 32, 0}, '{1, 0, 0, 0}, '{13, 14, 15, 0}};
        for (int t = 0; t < 3; t++) begin
            bus.mdb_in = w[t];
            bus.stall  = 1'b0;
            for (int i = 0; i < n[t]; i++) begin
                @(posedge clk);
                @(negedge clk);
                checks++;
                if (int'(bus.car) !== ec[t][i] || bus.ir !== w[t] ||
                    bus.instr_done !== (i == n[t] - 1) ||
                    {bus.int_ack, bus.illegal} !== 2'b00) begin
                    errors++;
                    $display("FAIL push_const_abs %h step %0d: car=%0d ir=%h pulses=%b, expected car=%0d done=%0d",
                             w[t], i, bus.car, bus.ir, {bus.int_ack, bus.instr_done, bus.illegal},
                             ec[t][i], (i == n[t] - 1));
                end
            end
            bus.stall = 1'b1;
        end
    endtask

    task automatic test_call_imm_1op();
        logic [15:0] w  [2]    = '{16'h12B0, 16'h1124};
        int          ec [2][4] = '{'{43, 44, 45, 0}, '{23, 24, 25, 0}};
        for (int t = 0; t < 2; t++) begin
            bus.mdb_in = w[t];
            bus.stall  = 1'b0;
            for (int i = 0; i < 4; i++) begin
                @(posedge clk);
                @(negedge clk);
                checks++;
                if (int'(bus.car) !== ec[t][i] || bus.instr_done !== (i == 3)) begin
                    errors++;
                    $display("FAIL call_imm_1op %h step %0d: car=%0d done=%b, expected car=%0d done=%0d",
                             w[t], i, bus.car, bus.instr_done, ec[t][i], (i == 3));
                end
            end
            bus.stall = 1'b1;
        end
    endtask

    task automatic test_jmp_int();
        int         ec [7] = '{57, 52, 53, 54, 55, 56, 0};
        logic [2:0] ep [7] = '{0, 3'b010, 0, 0, 0, 0, 3'b100};
        bus.mdb_in  = 16'h3FFF;
        bus.int_req = 1'b1;
        bus.stall   = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (int'(bus.car) !== ec[i] || bus.ir !== 16'h3FFF ||
                {bus.int_ack, bus.instr_done, bus.illegal} !== ep[i]) begin
                errors++;
                $display("FAIL jmp_int step %0d: car=%0d ir=%h pulses=%b, expected car=%0d ir=3fff pulses=%b",
                         i, bus.car, bus.ir, {bus.int_ack, bus.instr_done, bus.illegal}, ec[i], ep[i]);
            end
        end
        bus.stall   = 1'b1;
        bus.int_req = 1'b0;
    endtask

    task automatic test_illegal_reti();
        logic [15:0] bad [2] = '{16'h0000, 16'h1380};
        int          ec  [3] = '{50, 51, 0};
        for (int t = 0; t < 2; t++) begin
            bus.mdb_in = bad[t];
            bus.stall  = 1'b0;
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (bus.car !== 6'd0 || bus.ir !== bad[t] ||
                {bus.int_ack, bus.instr_done, bus.illegal} !== 3'b001) begin
                errors++;
                $display("FAIL illegal %h: car=%0d ir=%h pulses=%b, expected car=0 ir=%h pulses=001",
                         bad[t], bus.car, bus.ir, {bus.int_ack, bus.instr_done, bus.illegal}, bad[t]);
            end
        end
        bus.mdb_in = 16'h1300;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (int'(bus.car) !== ec[i] || bus.ir !== 16'h1300 ||
                bus.illegal !== 1'b0 || bus.instr_done !== (i == 2)) begin
                errors++;
                $display("FAIL reti step %0d: car=%0d ir=%h pulses=%b, expected car=%0d ir=1300 done=%0d",
                         i, bus.car, bus.ir, {bus.int_ack, bus.instr_done, bus.illegal}, ec[i], (i == 2));
            end
        end
        bus.stall = 1'b1;
    endtask

    task automatic test_back_to_back();
        int          ec [3] = '{1, 0, 30};
        logic [15:0] ei [3] = '{16'h4405, 16'h4405, 16'h1204};
        bus.mdb_in = 16'h4405;
        bus.stall  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            bus.mdb_in = 16'h1204;
            checks++;
            if (int'(bus.car) !== ec[i] || bus.ir !== ei[i] ||
                bus.instr_done !== (i == 1)) begin
                errors++;
                $display("FAIL back_to_back step %0d: car=%0d ir=%h done=%b, expected car=%0d ir=%h done=%0d",
                         i, bus.car, bus.ir, bus.instr_done, ec[i], ei[i], (i == 1));
            end
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus.stall = 1'b1;
        checks++;
        if (bus.car !== 6'd0) begin
            errors++;
            $display("FAIL back_to_back_tail: car=%0d, expected car=0", bus.car);
        end
    endtask

    task automatic test_stall();
        int         ec [9] = '{8, 9, 10, 10, 10, 10, 11, 12, 0};
        logic       sv [9] = '{0, 0, 1, 1, 1, 0, 0, 0, 1};
        logic [2:0] ep [9] = '{0, 0, 0, 0, 0, 0, 0, 0, 3'b010};
        bus.mdb_in = 16'h54B5;
        bus.stall  = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk);
            @(negedge clk);
            bus.stall = sv[i];
            checks++;
            if (int'(bus.car) !== ec[i] || bus.ir !== 16'h54B5 ||
                {bus.int_ack, bus.instr_done, bus.illegal} !== ep[i]) begin
                errors++;
                $display("FAIL stall step %0d: car=%0d ir=%h pulses=%b, expected car=%0d pulses=%b",
                         i, bus.car, bus.ir, {bus.int_ack, bus.instr_done, bus.illegal}, ec[i], ep[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        int ec [2] = '{16, 17};
        bus.mdb_in = 16'h4495;
        bus.stall  = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (int'(bus.car) !== ec[i]) begin
                errors++;
                $display("FAIL idx_idx step %0d: car=%0d, expected car=%0d",
                         i, bus.car, ec[i]);
            end
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.car !== 6'd0 || bus.ir !== 16'h0000 ||
            {bus.int_ack, bus.instr_done, bus.illegal} !== 3'b000) begin
            errors++;
            $display("FAIL async_reset: car=%0d ir=%h pulses=%b, expected car=0 ir=0000 pulses=000",
                     bus.car, bus.ir, {bus.int_ack, bus.instr_done, bus.illegal});
        end
        @(negedge clk);
        bus.mdb_in = 16'h4405;
        rst        = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.car !== 6'd1 || bus.ir !== 16'h4405) begin
            errors++;
            $display("FAIL after_reset_fetch: car=%0d ir=%h, expected car=1 ir=4405",
                     bus.car, bus.ir);
        end
        bus.stall = 1'b1;
    endtask

    initial begin
        clk         = 1'b0;
        rst         = 1'b1;
        checks      = 0;
        errors      = 0;
        bus.mdb_in  = 16'h0000;
        bus.stall   = 1'b1;
        bus.int_req = 1'b0;
        @(negedge clk);
        test_reset();
        test_mov_reg();
        test_add_ind_idx();
        test_push_const_abs();
        test_call_imm_1op();
        test_jmp_int();
        test_illegal_reti();
        test_back_to_back();
        test_stall();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/car_sequencer.md
Name: car_sequencer

Overview:
- Microsequencer directly upstream of the CPU control unit. Owns the instruction register (IR) and the control address register (CAR).
- On each clock it advances CAR through the micro-step sequence for the current instruction's format and addressing modes.
- Captures fetched instruction words and inserts the interrupt entry sequence at instruction boundaries.
- Its car/ir outputs feed the control unit's CAR/IR inputs directly.

Parameters:
CAR_BITS, 6, width of the CAR output. All encodings below must fit.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
mdb_in  input  16  memory data bus; holds the fetched instruction word during CAR_0
stall  input  1  1 = hold CAR and IR this cycle (memory wait)
int_req  input  1  maskable interrupt pending (already qualified by GIE upstream)
car  output  CAR_BITS  current control address
ir  output  16  current instruction register
int_ack  output  1  one-cycle pulse in the cycle CAR=INT4 advances
instr_done  output  1  one-cycle pulse when a sequence's last step advances to CAR_0 or INT0
illegal  output  1  one-cycle pulse when an unsupported opcode is fetched

Behaviour:
- Reset (asynchronous):
  - car=0 (CAR_0), ir=16'h0000.
  - int_ack, instr_done and illegal are all 0.
  - Reset mid-sequence abandons the sequence; the first cycle after release is CAR_0.
- CAR encoding, decimal:
  - Fetch and format I: CAR_0=0, REG_REG=1, REG_IDX0..3=2..5, IND_REG0..1=6..7, IND_IDX0..4=8..12, IDX_REG0..2=13..15, IDX_IDX0..5=16..21.
  - Single-operand: 1OP_REG=22, 1OP_IND0..2=23..25, 1OP_IDX0..3=26..29.
  - PUSH/CALL: PUSH_REG0..2=30..32, PUSH_IND0..2=33..35, PUSH_IDX0..3=36..39, CALL_REG0..2=40..42, CALL_IND0..2=43..45, CALL_IDX0..3=46..49.
  - Other: RETI0..1=50..51, INT0..4=52..56, JMP=57.
  - Values 58+ are invalid; they go to CAR_0 on the next edge.
- Stall: when stall=1, car, ir and all pulses hold/suppress. Stall has priority over everything except rst.
- CAR_0 (fetch): ir <= mdb_in at the edge. The next CAR is decoded from mdb_in (same edge), so decode costs 0 extra cycles.
- Within a sequence: step k -> k+1. The last step of each sequence -> CAR_0, or INT0 if int_req=1 at that edge.
- CAR_0 itself is not a boundary for interrupts.
- Decode on mdb_in (w):
  - w[15:13]=001 -> JMP (single step).
  - w[15:10]=000100, by w[9:7]:
    - 000–011 (RRC/SWPB/RRA/SXT) -> 1OP group.
    - 100 -> PUSH group.
    - 101 -> CALL group.
    - 110 -> RETI0.
    - 111 -> illegal.
  - w[15:12]>=4 -> format I group; dst class is Ad=w[7] (0 reg, 1 idx).
  - Everything else (0x0000–0x0FFF extended/address, 0x1380–0x1FFF) -> illegal: pulse illegal, CAR stays at CAR_0.
- Source class from As=w[5:4], reg=format I ? w[11:8] : w[3:0]:
  - 00 -> REG.
  - 01 -> IDX.
  - 10/11 -> IND.
  - Constant-generator override: reg=R3 (any As), or reg=R2 with As=10/11 -> REG.
  - R2 with As=01 (absolute) stays IDX.
  - PC with As=11 (immediate) stays IND.
- Interrupt: INT0..INT4 run sequentially. int_ack pulses on the INT4 edge. INT4 -> CAR_0 regardless of int_req. ir is unchanged during INT.
- instr_done pulses on every last-step edge, including JMP and RETI1. It does not pulse for INT4.
- Reset value of car is CAR_0 even if int_req=1.

Test Plan:
- MOV R4,R5: mdb_in=16'h4405 at CAR_0 -> car sequence 0,1,0; ir=4405; instr_done pulses once.
- ADD @R4+,2(R5): 16'h54B5 -> car 0,8,9,10,11,12,0. PUSH R4 (16'h1204) -> 0,30,31,32,0.
- Constant generator MOV #0,R5 (16'h4305) -> 0,1,0. MOV &addr,R5 (16'h4215) -> 0,13,14,15,0.
- JMP $ (16'h3FFF) with int_req=1 -> 57,52,53,54,55,56,0; int_ack high only on the 56 edge; instr_done only on the 57 edge.
- Illegal 16'h0000 at CAR_0 -> illegal=1 for one cycle, car stays 0, ir=0000. Then 16'h1300 (RETI) -> 50,51,0.
- stall=1 for 3 cycles at car=10 -> car holds 10 and no pulses. Assert rst asynchronously at car=17 -> car=0 immediately, ir=0000, no pulses.
